// File: rtl/twelve_bit_accumulator.sv
// Multi-term 12-bit accumulator: adds or subtracts N handshaked terms through a
// single ripple-style 12-bit full adder and returns the result with a sticky overflow.

module twelveBitFullAdder (
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        cin,
    output logic [11:0] sum_c,
    output logic        cout_c
);
    assign {cout_c, sum_c} = 13'(a) + 13'(b) + 13'(cin);
endmodule

module twelve_bit_accumulator #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] N,
    input  logic             Sub,
    input  logic             in_valid,
    input  logic [11:0]      Data_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      Result,
    output logic             Overflow
);
    localparam int unsigned DATA_W = 12;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sub_q, sub_d;
    logic              first_q, first_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic              sub_term;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              accept;

    // The first subtract-mode term is loaded by adding it to the cleared accumulator.
    assign sub_term = sub_q & ~first_q;
    assign add_b    = sub_term ? ~Data_in : Data_in;
    assign accept   = in_valid & in_ready_q;

    twelveBitFullAdder u_adder (
        .a      (acc_q),
        .b      (add_b),
        .cin    (sub_term),
        .sum_c  (add_sum),
        .cout_c (add_cout)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        first_d = first_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = N;
                    sub_d   = Sub;
                    first_d = 1'b1;
                    state_d = (N == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d   = add_sum;
                    // Borrow in subtract mode is the absence of carry-out.
                    ovf_d   = ovf_q | (sub_term ? ~add_cout : add_cout);
                    cnt_d   = cnt_q - CNT_W'(1);
                    first_d = 1'b0;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            first_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            first_q     <= first_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Result    = acc_q;
    assign Overflow  = ovf_q;
endmodule

// File: tb/tb_twelve_bit_accumulator.sv
// Directed bench for twelve_bit_accumulator: arithmetic reference model checked every
// cycle, plus hand-computed literal results for each directed scenario.

module tb_twelve_bit_accumulator;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] N = '0;
    logic             Sub = 1'b0;
    logic             in_valid = 1'b0;
    logic [11:0]      Data_in = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [11:0]      Result;
    logic             Overflow;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model: phase 0 idle, 1 collecting terms, 2 result ready.
    int m_phase = 0;
    int m_acc   = 0;
    bit m_ovf   = 1'b0;
    int m_left  = 0;
    bit m_sub   = 1'b0;
    bit m_first = 1'b0;

    twelve_bit_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .N         (N),
        .Sub       (Sub),
        .in_valid  (in_valid),
        .Data_in   (Data_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_acc = 0; m_ovf = 0; m_left = 0; m_sub = 0; m_first = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_acc = 0; m_ovf = 0; m_sub = Sub; m_first = 1;
                    m_left = int'(N);
                    m_phase = (N == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    if (!m_sub) begin
                        if (m_acc + int'(Data_in) > 4095) m_ovf = 1;
                        m_acc = (m_acc + int'(Data_in)) % 4096;
                    end else if (m_first) begin
                        m_acc = int'(Data_in);
                    end else begin
                        if (int'(Data_in) > m_acc) m_ovf = 1;
                        m_acc = (m_acc - int'(Data_in) + 4096) % 4096;
                    end
                    m_first = 0;
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", int'(in_ready), (m_phase == 1) ? 1 : 0);
            check("out_valid", int'(out_valid), (m_phase == 2) ? 1 : 0);
            if (m_phase == 2) begin
                check("model_result", int'(Result), m_acc);
                check("model_overflow", int'(Overflow), int'(m_ovf));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input int n, input bit s);
        start = 1'b1; N = CNT_W'(n); Sub = s;
        tick();
        start = 1'b0; N = '0; Sub = 1'b0;
    endtask

    task automatic send(input int d);
        in_valid = 1'b1; Data_in = 12'(d);
        tick();
        in_valid = 1'b0; Data_in = '0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        if (!out_valid) check(name, 0, 1);
    endtask

    task automatic expect_done(input string name, input int res, input int ovf);
        wait_valid({name, "_timeout"});
        check({name, "_result"}, int'(Result), res);
        check({name, "_overflow"}, int'(Overflow), ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_back_idle"}, int'(out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(Result), 0);
        check("rst_overflow", int'(Overflow), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Add 100+200+300, result one cycle after final acceptance.
        do_start(3, 0);
        send(100); send(200); send(300);
        check("add3_latency", int'(out_valid), 1);
        expect_done("add3", 600, 0);

        do_start(2, 0);
        send(12'hFFF); send(12'h002);
        expect_done("add_wrap", 12'h001, 1);

        do_start(3, 1);
        send(12'h100); send(12'h030); send(12'h010);
        expect_done("sub3", 12'h0C0, 0);

        do_start(2, 1);
        send(12'h005); send(12'h006);
        expect_done("sub_borrow", 12'hFFF, 1);

        // Backpressure on both sides, stray start during the result phase.
        do_start(2, 0);
        send(7);
        tick(); tick(); tick();
        send(9);
        for (int i = 0; i < 5; i++) begin
            check("bp_result", int'(Result), 16);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            if (i == 2) do_start(5, 1); else tick();
        end
        expect_done("bp", 16, 0);

        // Reset mid-operation discards the partial sum.
        do_start(4, 0);
        send(12'h123);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_result", int'(Result), 0);
        check("abort_overflow", int'(Overflow), 0);
        do_start(1, 0);
        send(12'h0AB);
        expect_done("post_abort", 12'h0AB, 0);

        // Zero terms: immediate result, offered data is not consumed.
        do_start(0, 0);
        check("n0_valid", int'(out_valid), 1);
        check("n0_in_ready", int'(in_ready), 0);
        in_valid = 1'b1; Data_in = 12'h055;
        expect_done("n0", 0, 0);
        in_valid = 1'b0; Data_in = '0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
